seven_seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the fitness timer's common-segment 7-segment display bank.
- Holds a frame of NUM_DIGITS BCD digits and drives one digit at a time through a single shared BCD-to-segment decoder.
- Swaps in new frames only at frame boundaries (tear-free), with a blanking guard between digits, leading-zero suppression, and per-digit blink.
- Sits between the timer/counter logic and the board's segment and digit-select pins.

---
 rtl/seven_seg_pkg.sv | 36 +++
 rtl/bcd2seven_seg.sv | 28 ++
 rtl/seven_seg_scan_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   - Segment byte layout {a,b,c,d,e,f,g,dp}, MSB = a, active-high.
//   - Segment patterns for BCD digits 0..9 (dp bit always 0 here).
//   - Scan FSM state encoding.
package seven_seg_pkg;

  localparam int unsigned SEG_BIT_A  = 7;
  localparam int unsigned SEG_BIT_B  = 6;
  localparam int unsigned SEG_BIT_C  = 5;
  localparam int unsigned SEG_BIT_D  = 4;
  localparam int unsigned SEG_BIT_E  = 3;
  localparam int unsigned SEG_BIT_F  = 2;
  localparam int unsigned SEG_BIT_G  = 1;
  localparam int unsigned SEG_BIT_DP = 0;

  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DP_MASK = 8'h01;

  localparam logic [7:0] SEG_0 = 8'b1111_1100;
  localparam logic [7:0] SEG_1 = 8'b0110_0000;
  localparam logic [7:0] SEG_2 = 8'b1101_1010;
  localparam logic [7:0] SEG_3 = 8'b1111_0010;
  localparam logic [7:0] SEG_4 = 8'b0110_0110;
  localparam logic [7:0] SEG_5 = 8'b1011_0110;
  localparam logic [7:0] SEG_6 = 8'b1011_1110;
  localparam logic [7:0] SEG_7 = 8'b1110_0000;
  localparam logic [7:0] SEG_8 = 8'b1111_1110;
  localparam logic [7:0] SEG_9 = 8'b1111_0110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/bcd2seven_seg.sv
// Combinational BCD to 7-segment decoder.
//   bcd_i : 4-bit BCD code
//   seg_o : {a,b,c,d,e,f,g,dp}, dp always 0; codes 10..15 give all-off
module bcd2seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment bank.
//   clk, rst_n          : clock, asynchronous active-low reset
//   en                  : scan enable, 0 forces the display dark
//   upd_valid/upd_ready : frame handshake; frame lands in a pending register
//   upd_bcd             : digit i at [4i+3:4i], digit 0 rightmost
//   upd_dp, upd_blink   : per-digit decimal point / blink enable
//   lz_en               : live leading-zero suppression enable
//   SEG_DATA            : {a..g,dp}, active-high, registered
//   dig_en              : one-hot digit enable, registered with SEG_DATA
//   frame_done          : one-cycle pulse on the first guard cycle of a frame
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIGIT_CYCLES = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_bcd,
  input  logic [NUM_DIGITS-1:0]   upd_dp,
  input  logic [NUM_DIGITS-1:0]   upd_blink,
  input  logic                    lz_en,
  output logic [7:0]              SEG_DATA,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
  localparam int unsigned FRM_W   = $clog2(BLINK_FRAMES + 1);

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam scan_state_e      AFTER_DRIVE = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRM_W-1:0]        frm_q, frm_d;
  logic                    blink_ph_q, blink_ph_d;

  logic [4*NUM_DIGITS-1:0] act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;

  logic [4*NUM_DIGITS-1:0] pend_bcd_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q;
  logic [NUM_DIGITS-1:0]   pend_blink_q;
  logic                    pend_vld_q;

  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    done_q;

  logic                    drive_end, wrap, swap;
  logic [3:0]              cur_bcd;
  logic                    cur_dp, cur_blink, lz_hit, all_zero;
  logic [7:0]              dec_seg;

  assign upd_ready  = ~pend_vld_q;
  assign SEG_DATA   = seg_q;
  assign dig_en     = dig_q;
  assign frame_done = done_q;

  // Scan sequencing and frame bookkeeping.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    frm_d      = frm_q;
    blink_ph_d = blink_ph_q;
    drive_end  = (state_q == DRIVE) && (cnt_q == DRIVE_LAST);
    wrap       = drive_end && (idx_q == IDX_LAST);

    case (state_q)
      IDLE: begin
        if (en) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = AFTER_DRIVE;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRIVE: begin
        if (drive_end) begin
          cnt_d   = '0;
          idx_d   = wrap ? '0 : idx_q + IDX_W'(1);
          state_d = AFTER_DRIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d      = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        frm_d = frm_q + FRM_W'(1);
      end
    end

    // Disable overrides sequencing but keeps blink phase; a swap due on
    // this same edge still goes through below.
    if (!en) begin
      state_d    = IDLE;
      idx_d      = '0;
      cnt_d      = '0;
      frm_d      = '0;
      blink_ph_d = blink_ph_q;
    end

    swap        = pend_vld_q && (wrap || (state_q == IDLE));
    act_bcd_d   = swap ? pend_bcd_q   : act_bcd_q;
    act_dp_d    = swap ? pend_dp_q    : act_dp_q;
    act_blink_d = swap ? pend_blink_q : act_blink_q;
  end

  // Select the digit about to be driven and evaluate leading-zero suppression:
  // walking from the top digit down to digit 1, a digit is suppressed while
  // it and every digit above it are zero.
  always_comb begin
    cur_bcd   = '0;
    cur_dp    = 1'b0;
    cur_blink = 1'b0;
    lz_hit    = 1'b0;
    all_zero  = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur_bcd   = act_bcd_d[4*i +: 4];
        cur_dp    = act_dp_d[i];
        cur_blink = act_blink_d[i];
      end
    end
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      all_zero = all_zero && (act_bcd_d[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
      if ((idx_d == IDX_W'(NUM_DIGITS - 1 - k)) && all_zero) begin
        lz_hit = 1'b1;
      end
    end
  end

  bcd2seven_seg u_dec (
    .bcd_i (cur_bcd),
    .seg_o (dec_seg)
  );

  // Outputs are computed from next-state values so segments and digit
  // enable are registered together on the same edge as the state.
  always_comb begin
    seg_d = SEG_BLANK;
    dig_d = '0;
    if (state_d == DRIVE) begin
      seg_d = ((lz_en && lz_hit) || (blink_ph_d && cur_blink)) ? SEG_BLANK : dec_seg;
      seg_d = seg_d | (cur_dp ? SEG_DP_MASK : SEG_BLANK);
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        dig_d[i] = (idx_d == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      frm_q        <= '0;
      blink_ph_q   <= 1'b0;
      act_bcd_q    <= '0;
      act_dp_q     <= '0;
      act_blink_q  <= '0;
      pend_bcd_q   <= '0;
      pend_dp_q    <= '0;
      pend_blink_q <= '0;
      pend_vld_q   <= 1'b0;
      seg_q        <= SEG_BLANK;
      dig_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      frm_q       <= frm_d;
      blink_ph_q  <= blink_ph_d;
      act_bcd_q   <= act_bcd_d;
      act_dp_q    <= act_dp_d;
      act_blink_q <= act_blink_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
      done_q      <= wrap;
      if (upd_valid && upd_ready) begin
        pend_bcd_q   <= upd_bcd;
        pend_dp_q    <= upd_dp;
        pend_blink_q <= upd_blink;
        pend_vld_q   <= 1'b1;
      end else if (swap) begin
        pend_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_bcd = '0;
  logic [3:0]  upd_dp = '0;
  logic [3:0]  upd_blink = '0;
  logic        lz_en = 1'b0;
  logic [7:0]  SEG_DATA;
  logic [3:0]  dig_en;
  logic        frame_done;

  int unsigned checks = 0;
  int unsigned failures = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (1),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_bcd    (upd_bcd),
    .upd_dp     (upd_dp),
    .upd_blink  (upd_blink),
    .lz_en      (lz_en),
    .SEG_DATA   (SEG_DATA),
    .dig_en     (dig_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic [3:0]  dp;
    logic        lz;
    logic [31:0] exp;  // expected SEG_DATA, digit i at [8i+7:8i]
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Offer a frame while idle, then wait for the idle swap.
  task automatic load_frame(input logic [15:0] bcd, input logic [3:0] dp, input logic [3:0] blink);
    int unsigned n = 0;
    while (!upd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!upd_ready) timeout_fail("load ready");
    upd_bcd   = bcd;
    upd_dp    = dp;
    upd_blink = blink;
    upd_valid = 1'b1;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Checks one complete frame cycle-by-cycle starting at the first digit-0 cycle.
  task automatic run_frame(input logic [31:0] exp, input string tag);
    int unsigned n = 0;
    logic [3:0] ed;
    logic [7:0] es;
    logic       ef;
    @(negedge clk);
    while (dig_en != 4'b0001 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (dig_en != 4'b0001) begin
      timeout_fail({tag, " start"});
      return;
    end
    for (int unsigned c = 0; c < 20; c++) begin
      if (c != 0) @(negedge clk);
      if ((c % 5) < 4) begin
        ed = 4'b0001 << (c / 5);
        es = exp[8*(c/5) +: 8];
      end else begin
        ed = 4'b0000;
        es = 8'h00;
      end
      ef = (c == 19);
      chk($sformatf("%s c%0d {dig,seg,fd}", tag, c),
          {19'd0, dig_en, SEG_DATA, frame_done}, {19'd0, ed, es, ef});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned n;
    logic [31:0] exp_1234;
    vt[0] = '{16'h1234, 4'b0100, 1'b0, {8'b0110_0000, 8'b1101_1011, 8'b1111_0010, 8'b0110_0110}};
    vt[1] = '{16'h0070, 4'b0000, 1'b1, {8'b0000_0000, 8'b0000_0000, 8'b1110_0000, 8'b1111_1100}};
    vt[2] = '{16'h0000, 4'b0000, 1'b1, {8'b0000_0000, 8'b0000_0000, 8'b0000_0000, 8'b1111_1100}};
    vt[3] = '{16'h0000, 4'b0000, 1'b0, {8'b1111_1100, 8'b1111_1100, 8'b1111_1100, 8'b1111_1100}};
    vt[4] = '{16'hA5B9, 4'b1010, 1'b0, {8'b0000_0001, 8'b1011_0110, 8'b0000_0001, 8'b1111_0110}};
    vt[5] = '{16'h0809, 4'b0000, 1'b1, {8'b0000_0000, 8'b1111_1110, 8'b1111_1100, 8'b1111_0110}};
    vt[6] = '{16'h0600, 4'b1000, 1'b1, {8'b0000_0001, 8'b1011_1110, 8'b1111_1100, 8'b1111_1100}};
    vt[7] = '{16'h0A00, 4'b0000, 1'b1, {8'b0000_0000, 8'b0000_0000, 8'b1111_1100, 8'b1111_1100}};
    exp_1234 = {8'b0110_0000, 8'b1101_1010, 8'b1111_0010, 8'b0110_0110};

    // Reset: outputs must go dark asynchronously.
    #1 rst_n = 1'b0;
    #2;
    chk("reset SEG_DATA", {24'd0, SEG_DATA}, 32'h0);
    chk("reset dig_en", {28'd0, dig_en}, 32'h0);
    chk("reset frame_done", {31'd0, frame_done}, 32'h0);
    chk("reset upd_ready", {31'd0, upd_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven decode / suppression vectors.
    for (int unsigned v = 0; v < 8; v++) begin
      en = 1'b0;
      @(negedge clk);
      @(negedge clk);
      load_frame(vt[v].bcd, vt[v].dp, 4'b0000);
      lz_en = vt[v].lz;
      en = 1'b1;
      run_frame(vt[v].exp, $sformatf("vec%0d", v));
      en = 1'b0;
    end

    // Tear-free update with a stalled second offer.
    @(negedge clk);
    @(negedge clk);
    lz_en = 1'b0;
    load_frame(16'h1234, 4'b0000, 4'b0000);
    en = 1'b1;
    n = 0;
    while (dig_en != 4'b0010 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (dig_en != 4'b0010) timeout_fail("tear wait digit1");
    upd_bcd   = 16'h5678;
    upd_valid = 1'b1;
    @(posedge clk);
    #1 upd_bcd = 16'h9999;
    n = 0;
    @(negedge clk);
    while (!frame_done && n < 40) begin
      chk($sformatf("tear ready low n%0d", n), {31'd0, upd_ready}, 32'h0);
      for (int unsigned d = 0; d < 4; d++) begin
        if (dig_en == (4'b0001 << d))
          chk($sformatf("tear old frame d%0d n%0d", d, n), {24'd0, SEG_DATA}, {24'd0, exp_1234[8*d +: 8]});
      end
      @(negedge clk);
      n++;
    end
    if (!frame_done) timeout_fail("tear frame_done");
    chk("tear ready after swap", {31'd0, upd_ready}, 32'h1);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    chk("tear second offer accepted", {31'd0, upd_ready}, 32'h0);
    run_frame({8'b1011_0110, 8'b1011_1110, 8'b1110_0000, 8'b1111_1110}, "tear new 5678");
    run_frame({4{8'b1111_0110}}, "tear next 9999");

    // Blink: fresh reset so blink phase starts at 0.
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load_frame(16'h0008, 4'b0000, 4'b0001);
    en = 1'b1;
    for (int unsigned f = 0; f < 6; f++) begin
      run_frame({8'b1111_1100, 8'b1111_1100, 8'b1111_1100,
                 (f == 2 || f == 3) ? 8'b0000_0000 : 8'b1111_1110},
                $sformatf("blink f%0d", f));
    end

    // Asynchronous reset in the middle of a drive period.
    n = 0;
    @(negedge clk);
    while (dig_en == 4'b0000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (dig_en == 4'b0000) timeout_fail("areset wait drive");
    #2 rst_n = 1'b0;
    #1;
    chk("areset SEG_DATA", {24'd0, SEG_DATA}, 32'h0);
    chk("areset dig_en", {28'd0, dig_en}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame({4{8'b1111_1100}}, "areset restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
